// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings,
// FSM states and the default busy latencies.
package md_pkg;

  // Operation codes carried on the mdop bus from decode.
  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } mdop_e;

  // Controller states: IDLE accepts new work, RUN counts down an in-flight op.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // Default number of busy cycles for each long-latency class.
  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  // True for the operations that occupy the unit for several cycles.
  function automatic logic isLongOp(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) ||
           (op == MD_DIV)  || (op == MD_DIVU);
  endfunction

  // True for the two divide flavours, which use the longer latency.
  function automatic logic isDivOp(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit. The full 64-bit result is computed
// combinationally at issue and parked in hi_n/lo_n; a down-counter then
// models the pipeline latency before the result lands in HI/LO.
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        req,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDO
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  md_state_e   r_state;
  md_state_e   w_nextState;
  logic [3:0]  r_cnt;
  logic [31:0] r_hiNext;
  logic [31:0] r_loNext;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_accept;
  logic        w_issueLong;
  logic        w_lastCycle;
  logic [3:0]  w_loadCnt;

  logic [63:0] w_mulSigned;
  logic [63:0] w_mulUnsigned;
  logic        w_divByZero;
  logic [31:0] w_divisor;
  logic [31:0] w_absA;
  logic [31:0] w_absB;
  logic [31:0] w_magQuot;
  logic [31:0] w_magRem;
  logic [31:0] w_sQuot;
  logic [31:0] w_sRem;
  logic [31:0] w_uQuot;
  logic [31:0] w_uRem;
  logic [31:0] w_resHi;
  logic [31:0] w_resLo;

  // An issue only counts in IDLE and only when no flush is pending; work
  // already in RUN ignores both start and req.
  assign w_accept    = start && !req && (r_state == ST_IDLE);
  assign w_issueLong = w_accept && isLongOp(mdop);
  assign w_loadCnt   = isDivOp(mdop) ? DIV_CNT : MULT_CNT;
  assign w_lastCycle = (r_state == ST_RUN) && (r_cnt <= 4'd1);

  // Products: sign- or zero-extend to 64 bits so the low 64 bits of the
  // product are the exact result in both flavours.
  assign w_mulSigned   = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign w_mulUnsigned = {32'd0, A} * {32'd0, B};

  // Divides are done on magnitudes so the signed case never hits the
  // INT_MIN / -1 host overflow; a zero divisor is replaced by 1 purely to
  // keep the divider defined, its result is discarded below.
  assign w_divByZero = (B == 32'd0);
  assign w_divisor   = w_divByZero ? 32'd1 : B;
  assign w_absA      = A[31] ? (32'd0 - A) : A;
  assign w_absB      = w_divisor[31] ? (32'd0 - w_divisor) : w_divisor;
  assign w_magQuot   = w_absA / w_absB;
  assign w_magRem    = w_absA % w_absB;
  assign w_sQuot     = (A[31] ^ w_divisor[31]) ? (32'd0 - w_magQuot) : w_magQuot;
  assign w_sRem      = A[31] ? (32'd0 - w_magRem) : w_magRem;
  assign w_uQuot     = A / w_divisor;
  assign w_uRem      = A % w_divisor;

  // Select the result to stage at issue; a divide by zero stages the
  // current HI/LO so the eventual commit leaves them unchanged.
  always_comb begin
    w_resHi = r_hi;
    w_resLo = r_lo;
    case (mdop)
      MD_MULT: begin
        w_resHi = w_mulSigned[63:32];
        w_resLo = w_mulSigned[31:0];
      end
      MD_MULTU: begin
        w_resHi = w_mulUnsigned[63:32];
        w_resLo = w_mulUnsigned[31:0];
      end
      MD_DIV: begin
        if (!w_divByZero) begin
          w_resHi = w_sRem;
          w_resLo = w_sQuot;
        end
      end
      MD_DIVU: begin
        if (!w_divByZero) begin
          w_resHi = w_uRem;
          w_resLo = w_uQuot;
        end
      end
      default: begin
        w_resHi = r_hi;
        w_resLo = r_lo;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // FSM next-state: leave IDLE on an accepted long op, return on the last count.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_issueLong) begin
          w_nextState = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_lastCycle) begin
          w_nextState = ST_IDLE;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Latency counter: loaded at issue, decremented every RUN cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= 4'd0;
    end else if (w_issueLong) begin
      r_cnt <= w_loadCnt;
    end else if (r_state == ST_RUN) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Staging registers hold the pending result for the duration of RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hiNext <= 32'd0;
      r_loNext <= 32'd0;
    end else if (w_issueLong) begin
      r_hiNext <= w_resHi;
      r_loNext <= w_resLo;
    end
  end

  // Architectural HI/LO: written by mthi/mtlo at issue or by the commit
  // at the end of a multi-cycle op (the two can never coincide).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (w_lastCycle) begin
      r_hi <= r_hiNext;
      r_lo <= r_loNext;
    end else if (w_accept && (mdop == MD_MTHI)) begin
      r_hi <= A;
    end else if (w_accept && (mdop == MD_MTLO)) begin
      r_lo <= A;
    end
  end

  // Read port for mfhi/mflo, combinational so M sees it next cycle.
  always_comb begin
    MDO = 32'd0;
    case (mdop)
      MD_MFHI: MDO = r_hi;
      MD_MFLO: MDO = r_lo;
      default: MDO = 32'd0;
    endcase
  end

  assign busy = (r_state == ST_RUN);
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: signed/unsigned mult and div, HI/LO moves,
// divide by zero, flush suppression and asynchronous reset mid-operation.
module tb_md_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  mdop;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        req;
  logic        busy;
  logic [31:0] hiOut;
  logic [31:0] loOut;
  logic [31:0] mdoOut;

  int checkCount = 0;
  int errorCount = 0;

  md_unit #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .mdop (mdop),
    .A    (opA),
    .B    (opB),
    .req  (req),
    .busy (busy),
    .HI   (hiOut),
    .LO   (loOut),
    .MDO  (mdoOut)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Hard stop in case something wedges the sequence below.
  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      errorCount++;
      $error("[TB] FAIL %s observed=%08h expected=%08h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for one cycle; returns one step after the issue edge.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic flush);
    start = 1'b1;
    mdop  = op;
    opA   = a;
    opB   = b;
    req   = flush;
    nextCycle();
    start = 1'b0;
    mdop  = MD_NONE;
    req   = 1'b0;
  endtask

  // Count busy cycles until the unit goes idle, bounded.
  task automatic waitIdle(input string tag, input int expectedCycles);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      nextCycle();
    end
    checkOutput(tag, 32'(n), 32'(expectedCycles));
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    mdop  = MD_NONE;
    opA   = 32'd0;
    opB   = 32'd0;
    req   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_hi", hiOut, 32'd0);
    checkOutput("reset_lo", loOut, 32'd0);
    checkOutput("reset_mdo", mdoOut, 32'd0);

    // -3 * 5 = -15
    applyStimulus(MD_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0);
    waitIdle("mult_busy_cycles", 5);
    checkOutput("mult_hi", hiOut, 32'hFFFF_FFFF);
    checkOutput("mult_lo", loOut, 32'hFFFF_FFF1);

    // 0xFFFFFFFF * 2 = 0x1_FFFFFFFE
    applyStimulus(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
    waitIdle("multu_busy_cycles", 5);
    checkOutput("multu_hi", hiOut, 32'h0000_0001);
    checkOutput("multu_lo", loOut, 32'hFFFF_FFFE);

    // -7 / 2 = -3 rem -1
    applyStimulus(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    waitIdle("div_busy_cycles", 10);
    checkOutput("div_lo", loOut, 32'hFFFF_FFFD);
    checkOutput("div_hi", hiOut, 32'hFFFF_FFFF);

    // Issued in the very cycle busy fell: 7 / 2 = 3 rem 1
    applyStimulus(MD_DIVU, 32'd7, 32'd2, 1'b0);
    waitIdle("divu_busy_cycles", 10);
    checkOutput("divu_lo", loOut, 32'd3);
    checkOutput("divu_hi", hiOut, 32'd1);

    // Combinational reads
    mdop = MD_MFHI;
    #1;
    checkOutput("mfhi_mdo", mdoOut, 32'd1);
    mdop = MD_MFLO;
    #1;
    checkOutput("mflo_mdo", mdoOut, 32'd3);
    mdop = MD_MULT;
    #1;
    checkOutput("mdo_other_op", mdoOut, 32'd0);
    mdop = MD_NONE;
    nextCycle();

    // mthi then divide by zero leaves HI/LO alone
    applyStimulus(MD_MTHI, 32'h0000_1234, 32'd0, 1'b0);
    checkOutput("mthi_hi", hiOut, 32'h0000_1234);
    checkOutput("mthi_busy", {31'd0, busy}, 32'd0);
    applyStimulus(MD_DIV, 32'd5, 32'd0, 1'b0);
    waitIdle("divzero_busy_cycles", 10);
    checkOutput("divzero_hi", hiOut, 32'h0000_1234);
    checkOutput("divzero_lo", loOut, 32'd3);

    // Flushed mult never starts
    applyStimulus(MD_MULT, 32'd3, 32'd4, 1'b1);
    checkOutput("flush_mult_busy", {31'd0, busy}, 32'd0);
    repeat (6) nextCycle();
    checkOutput("flush_mult_hi", hiOut, 32'h0000_1234);
    checkOutput("flush_mult_lo", loOut, 32'd3);

    // Flushed mtlo is dropped, unflushed one lands
    applyStimulus(MD_MTLO, 32'h0000_DEAD, 32'd0, 1'b1);
    checkOutput("flush_mtlo_lo", loOut, 32'd3);
    applyStimulus(MD_MTLO, 32'h0000_BEEF, 32'd0, 1'b0);
    checkOutput("mtlo_lo", loOut, 32'h0000_BEEF);

    // -2 * -3 = 6
    applyStimulus(MD_MULT, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0);
    waitIdle("mult_negneg_cycles", 5);
    checkOutput("mult_negneg_hi", hiOut, 32'd0);
    checkOutput("mult_negneg_lo", loOut, 32'd6);

    // 7 / -2 = -3 rem 1
    applyStimulus(MD_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0);
    waitIdle("div_negdivisor_cycles", 10);
    checkOutput("div_negdivisor_lo", loOut, 32'hFFFF_FFFD);
    checkOutput("div_negdivisor_hi", hiOut, 32'd1);

    // req raised while running does not cancel the op
    applyStimulus(MD_MULTU, 32'd3, 32'd4, 1'b0);
    req = 1'b1;
    waitIdle("req_in_run_cycles", 5);
    req = 1'b0;
    checkOutput("req_in_run_hi", hiOut, 32'd0);
    checkOutput("req_in_run_lo", loOut, 32'd12);

    // Asynchronous reset in the third busy cycle of a divide
    applyStimulus(MD_DIV, 32'd100, 32'd7, 1'b0);
    nextCycle();
    nextCycle();
    checkOutput("pre_reset_busy", {31'd0, busy}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
    checkOutput("midreset_hi", hiOut, 32'd0);
    checkOutput("midreset_lo", loOut, 32'd0);
    nextCycle();
    reset = 1'b0;
    repeat (12) nextCycle();
    checkOutput("postreset_busy", {31'd0, busy}, 32'd0);
    checkOutput("postreset_hi", hiOut, 32'd0);
    checkOutput("postreset_lo", loOut, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/md_unit.md
# md_unit

Multi-cycle multiply/divide unit in the EX stage that produces the MD-read result forwarded out of the M stage. It executes signed and unsigned mult and div, plus mthi, mtlo, mfhi and mflo, on architectural HI/LO registers. It exposes `busy` to the stall controller, and `req` lets an exception or interrupt in M cancel an instruction that is being issued.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for mult/multu.
- `DIV_CYCLES`, default 10: busy cycles for div/divu.

Ports:
- `clk` input, 1 bit: rising-edge clock.
- `reset` input, 1 bit: asynchronous, active-high.
- `start` input, 1 bit: issue strobe for the EX-stage instruction. Sampled at the rising edge.
- `mdop` input, 4 bits: operation code from the shared package.
- `A` input, 32 bits: rs operand, already forwarded.
- `B` input, 32 bits: rt operand, already forwarded.
- `req` input, 1 bit: exception/interrupt flush. When high, it suppresses this cycle's issue.
- `busy` output, 1 bit: a multiply or divide is in flight.
- `HI` output, 32 bits: architectural HI register.
- `LO` output, 32 bits: architectural LO register.
- `MDO` output, 32 bits: read data. Equals `HI` for mfhi, `LO` for mflo, and 0 otherwise. Combinational from `mdop`, `HI` and `LO`.

## Operation
- State machine: IDLE and RUN. The down-counter `cnt` is 4 bits.
- In IDLE, when `start` is high, `req` is low and `mdop` is mult/multu/div/divu:
  - latch the full result into internal `hi_n`/`lo_n`;
  - load `cnt` with the cycle count for that op;
  - go to RUN.
- In IDLE with `start` high and `req` low:
  - mthi writes `HI`←`A` at that edge;
  - mtlo writes `LO`←`A` at that edge.
- In RUN, `cnt` decrements every cycle. On the edge where `cnt`==1:
  - `HI`←`hi_n` and `LO`←`lo_n`;
  - go to IDLE.
- Arithmetic:
  - mult: 64-bit signed product; `HI` = bits [63:32], `LO` = bits [31:0].
  - multu: same, unsigned.
  - div: signed; `LO` = quotient truncated toward zero; `HI` = remainder, carrying the sign of the dividend.
  - divu: unsigned.
- Divide by zero: the full busy time elapses, then `HI`/`LO` are left unchanged.
- `start` while `busy`: ignored. The stall controller guarantees it never occurs.
- `req` while in RUN: no effect. An op already in flight always completes.
- `reset` at any time, including mid-operation: state→IDLE, `cnt`←0, `busy`←0, `HI`←0, `LO`←0, `hi_n`/`lo_n`←0.

## Timing
- Reset values: `busy`=0, `HI`=0, `LO`=0, `MDO`=0.
- Issue at the edge closing cycle t:
  - `busy` is high in cycles t+1 … t+N, where N = `MULT_CYCLES` or `DIV_CYCLES`;
  - `busy` falls, and new `HI`/`LO` are visible, in cycle t+N+1.
- `busy` is registered. The stall controller stalls an MD instruction in D when `busy` is high, or when `start` is high with a mult/div `mdop`.
- mthi/mtlo take effect one cycle after issue.
- mfhi/mflo read combinationally in the same cycle. `MDO` is pipelined to M externally.
- Issue is accepted in the same cycle `busy` falls (cycle t+N+1). There is no bubble required between ops.

## Structure
- Shared package `md_pkg` holds:
  - `mdop` encodings: MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MFHI=5, MD_MFLO=6, MD_MTHI=7, MD_MTLO=8;
  - the default latency constants.
- Single module, no sub-module. The 64-bit result computation is an inline combinational block feeding `hi_n`/`lo_n`.

## Test plan
- Signed mult: mult `A`=0xFFFFFFFD, `B`=5 → `busy` high for exactly 5 cycles, then `HI`=0xFFFFFFFF, `LO`=0xFFFFFFF1.
- Unsigned mult: multu 0xFFFFFFFF×2 → `HI`=0x00000001, `LO`=0xFFFFFFFE.
- Signed div: div `A`=0xFFFFFFF9 (−7), `B`=2 → `busy` for 10 cycles, then `LO`=0xFFFFFFFD, `HI`=0xFFFFFFFF.
- Unsigned div then read: divu 7/2 → `LO`=3, `HI`=1; mfhi the next cycle → `MDO`=1.
- Divide by zero: after mthi 0x1234, div by 0 → `busy` for 10 cycles, `HI` stays 0x1234.
- Flush and reset:
  - mult with `req`=1 → `busy` stays 0, `HI`/`LO` unchanged;
  - mtlo with `req`=1 → `LO` unchanged;
  - `reset` in cycle 3 of a div → `busy`=0, `HI`=`LO`=0 immediately.
